// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: D-stage descriptor bus into the hazard scoreboard, and the stall/forward/busy results back out.
interface hazard_scoreboard_if #(
  parameter int STAGES = 4,
  parameter int ADDR_W = 7,
  parameter int T_W    = 4
);
  localparam int SEL_W = $clog2(STAGES + 1);
  logic              d_valid;
  logic [T_W-1:0]    d_tuse1;
  logic [T_W-1:0]    d_tuse2;
  logic [ADDR_W-1:0] d_ause1;
  logic [ADDR_W-1:0] d_ause2;
  logic [T_W-1:0]    d_tnew;
  logic [ADDR_W-1:0] d_anew;
  logic              d_md_start;
  logic              d_md_div;
  logic              d_md_use;
  logic              stall;
  logic [SEL_W-1:0]  fwd_sel1;
  logic [SEL_W-1:0]  fwd_sel2;
  logic              md_busy;
  modport master (
    output d_valid, d_tuse1, d_tuse2, d_ause1, d_ause2, d_tnew, d_anew,
           d_md_start, d_md_div, d_md_use,
    input  stall, fwd_sel1, fwd_sel2, md_busy
  );
  modport slave (
    input  d_valid, d_tuse1, d_tuse2, d_ause1, d_ause2, d_tnew, d_anew,
           d_md_start, d_md_div, d_md_use,
    output stall, fwd_sel1, fwd_sel2, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tuse/Tnew stall + forwarding controller with mult/div busy interlock.
// Define HAZ_FWD_EN to enable forwarding; otherwise any in-flight producer before W stalls.
module hazard_scoreboard #(
  parameter int STAGES      = 4,
  parameter int ADDR_W      = 7,
  parameter int T_W         = 4,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic rst_n,
  hazard_scoreboard_if.slave bus
);
  localparam int SEL_W   = $clog2(STAGES + 1);
  localparam int CNT_MAX = DIV_CYCLES > MULT_CYCLES ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [STAGES-1:0] vld_q;
  logic [ADDR_W-1:0] tag_q  [STAGES];
  logic [T_W-1:0]    tnew_q [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ause [2];
  logic [1:0]        haz;
  logic [SEL_W-1:0]  sel [2];
  logic              md_busy, issue;

  function automatic logic [T_W-1:0] dec_sat(input logic [T_W-1:0] t);
    return t == '0 ? t : t - 1'b1;
  endfunction

  assign ause[0] = bus.d_ause1;
  assign ause[1] = bus.d_ause2;

  // Scan oldest to youngest so the youngest matching producer has the last word.
  always_comb begin
    haz    = '0;
    sel[0] = '0;
    sel[1] = '0;
    for (int s = 0; s < 2; s++)
      for (int k = STAGES - 1; k >= 0; k--)
`ifdef HAZ_FWD_EN
        if (vld_q[k] && tag_q[k] == ause[s] && ause[s] != '0) begin
          haz[s] = tnew_q[k] > (s == 0 ? bus.d_tuse1 : bus.d_tuse2);
          sel[s] = tnew_q[k] == '0 ? SEL_W'(k + 1) : '0;
        end
`else
        if (k < STAGES - 1 && vld_q[k] && tag_q[k] == ause[s] && ause[s] != '0)
          haz[s] = 1'b1;
`endif
  end

  assign md_busy      = cnt_q != '0;
  assign bus.stall    = bus.d_valid & ((|haz) | (bus.d_md_use & md_busy));
  assign bus.fwd_sel1 = sel[0];
  assign bus.fwd_sel2 = sel[1];
  assign bus.md_busy  = md_busy;
  assign issue        = bus.d_valid & ~bus.stall;

  assign cnt_d = (issue && bus.d_md_start) ? (bus.d_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES))
               : md_busy ? cnt_q - 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        tag_q[k]  <= '0;
        tnew_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      for (int k = STAGES - 1; k > 0; k--) begin
        vld_q[k]  <= vld_q[k-1];
        tag_q[k]  <= tag_q[k-1];
        tnew_q[k] <= dec_sat(tnew_q[k-1]);
      end
      vld_q[0]  <= issue & (bus.d_anew != '0);
      tag_q[0]  <= bus.d_anew;
      tnew_q[0] <= dec_sat(bus.d_tnew);
      cnt_q     <= cnt_d;
    end
endmodule
